refclk_tx_gate_ctrl: RTL and testbench

Fabric-side control stage that drives the data input (I) and active-low enable (CEB) of the GT reference-clock differential output buffer. It generates a divided forwarding clock from the fabric clock and sequences the buffer's enable and the clock toggling glitch-free. The buffer is enabled before the first edge and disabled only after the last full low phase plus a drain interval, so no runt pulses ever reach the pads.

---
 rtl/refclk_tx_gate_ctrl.sv | 153 +++++++++++++++
 tb/tb_refclk_tx_gate_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/refclk_tx_gate_ctrl.sv
// Control stage for the GT reference-clock output buffer: divides the fabric clock and
// sequences the active-low buffer enable so that no runt pulse ever reaches the pads.
module refclk_tx_gate_ctrl #(
    parameter int DIV_W         = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int DRAIN_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             clk_out,
    output logic             ceb,
    output logic             active,
    output logic             busy
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_SETTLE = 3'd1,
        ST_RUN    = 3'd2,
        ST_STOP   = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    localparam logic [15:0] SETTLE_INIT = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] DRAIN_INIT  = 16'(DRAIN_CYCLES - 1);

    state_t             state_r, state_s;
    logic [DIV_W-1:0]   cnt_r, cnt_s;
    logic [DIV_W-1:0]   div_r, div_s;
    logic [15:0]        timer_r, timer_s;
    logic               clk_out_r, clk_out_s;
    logic               ceb_r, ceb_s;
    logic               active_r, active_s;
    logic               busy_r, busy_s;
    logic               wrap_s;

    assign clk_out = clk_out_r;
    assign ceb     = ceb_r;
    assign active  = active_r;
    assign busy    = busy_r;

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_OFF;
            cnt_r     <= '0;
            div_r     <= '0;
            timer_r   <= 16'd0;
            clk_out_r <= 1'b0;
            ceb_r     <= 1'b1;
            active_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            div_r     <= div_s;
            timer_r   <= timer_s;
            clk_out_r <= clk_out_s;
            ceb_r     <= ceb_s;
            active_r  <= active_s;
            busy_r    <= busy_s;
        end
    end

    // Next-state and next-output decode; outputs are computed for the state being entered.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        div_s     = div_r;
        timer_s   = timer_r;
        clk_out_s = 1'b0;
        ceb_s     = 1'b0;
        active_s  = 1'b0;
        busy_s    = 1'b0;
        wrap_s    = (cnt_r == div_r);

        case (state_r)
            ST_OFF: begin
                if (en) begin
                    state_s = ST_SETTLE;
                    timer_s = SETTLE_INIT;
                    busy_s  = 1'b1;
                end else begin
                    ceb_s   = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!en) begin
                    state_s = ST_DRAIN;
                    timer_s = DRAIN_INIT;
                    busy_s  = 1'b1;
                end else if (timer_r == 16'd0) begin
                    state_s   = ST_RUN;
                    clk_out_s = 1'b1;
                    div_s     = div;
                    cnt_s     = '0;
                    active_s  = 1'b1;
                end else begin
                    timer_s = timer_r - 16'd1;
                    busy_s  = 1'b1;
                end
            end
            ST_RUN: begin
                if (wrap_s) begin
                    clk_out_s = ~clk_out_r;
                    cnt_s     = '0;
                end else begin
                    clk_out_s = clk_out_r;
                    cnt_s     = cnt_r + DIV_W'(1);
                end
                if (en) begin
                    active_s = 1'b1;
                end else begin
                    state_s = ST_STOP;
                    busy_s  = 1'b1;
                end
            end
            ST_STOP: begin
                busy_s = 1'b1;
                if (!wrap_s) begin
                    clk_out_s = clk_out_r;
                    cnt_s     = cnt_r + DIV_W'(1);
                end else if (clk_out_r) begin
                    clk_out_s = 1'b0;
                    cnt_s     = '0;
                end else begin
                    // The rise that would follow the last full low phase is suppressed.
                    state_s = ST_DRAIN;
                    timer_s = DRAIN_INIT;
                    cnt_s   = '0;
                end
            end
            ST_DRAIN: begin
                if (timer_r == 16'd0) begin
                    state_s = ST_OFF;
                    ceb_s   = 1'b1;
                end else begin
                    timer_s = timer_r - 16'd1;
                    busy_s  = 1'b1;
                end
            end
            default: begin
                state_s = ST_OFF;
                cnt_s   = '0;
                timer_s = 16'd0;
                ceb_s   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_refclk_tx_gate_ctrl.sv
// Scoreboard bench: a phase-duration reference model predicts each cycle's outputs,
// a separate monitor compares them against the DUT half a step after every edge.
module tb_refclk_tx_gate_ctrl;

    localparam int DIV_W         = 8;
    localparam int SETTLE_CYCLES = 16;
    localparam int DRAIN_CYCLES  = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] div;
    logic             clk_out;
    logic             ceb;
    logic             active;
    logic             busy;

    refclk_tx_gate_ctrl #(
        .DIV_W(DIV_W),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .div(div),
        .clk_out(clk_out),
        .ceb(ceb),
        .active(active),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic ceb;
        logic clk_out;
        logic active;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   tests    = 0;
    int   failures = 0;
    int   cycle    = 0;

    // Reference model: modes plus "edges left until the next event" counts.
    typedef enum int {M_OFF, M_SETTLE, M_RUN, M_STOP, M_DRAIN} mode_t;
    mode_t m_mode      = M_OFF;
    int    m_left      = 0;
    int    m_level     = 0;
    int    m_phase_len = 1;

    task automatic model_step(input logic r, input logic e, input int d);
        if (r) begin
            m_mode  = M_OFF;
            m_level = 0;
            m_left  = 0;
        end else begin
            case (m_mode)
                M_OFF: begin
                    if (e) begin
                        m_mode = M_SETTLE;
                        m_left = SETTLE_CYCLES;
                    end
                end
                M_SETTLE: begin
                    if (!e) begin
                        m_mode = M_DRAIN;
                        m_left = DRAIN_CYCLES;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_mode      = M_RUN;
                            m_level     = 1;
                            m_phase_len = d + 1;
                            m_left      = m_phase_len;
                        end
                    end
                end
                M_RUN, M_STOP: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_mode == M_STOP && m_level == 0) begin
                            m_mode = M_DRAIN;
                            m_left = DRAIN_CYCLES;
                        end else begin
                            m_level = 1 - m_level;
                            m_left  = m_phase_len;
                        end
                    end
                    if (m_mode == M_RUN && !e) m_mode = M_STOP;
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_mode = M_OFF;
                end
            endcase
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [DIV_W-1:0] d);
        exp_t x;
        @(negedge clk);
        rst = r;
        en  = e;
        div = d;
        @(posedge clk);
        cycle++;
        model_step(r, e, int'(d));
        x.cyc     = cycle;
        x.ceb     = (m_mode == M_OFF);
        x.clk_out = (m_mode == M_RUN || m_mode == M_STOP) ? logic'(m_level) : 1'b0;
        x.active  = (m_mode == M_RUN);
        x.busy    = (m_mode == M_SETTLE || m_mode == M_STOP || m_mode == M_DRAIN);
        exp_q.push_back(x);
    endtask

    // Monitor: compares one expected record per edge, plus the enable/clock invariant.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                tests++;
                if ({ceb, clk_out, active, busy} !== {x.ceb, x.clk_out, x.active, x.busy}) begin
                    failures++;
                    $display("FAIL outputs cycle %0d: got ceb=%b clk_out=%b active=%b busy=%b, expected ceb=%b clk_out=%b active=%b busy=%b",
                             x.cyc, ceb, clk_out, active, busy, x.ceb, x.clk_out, x.active, x.busy);
                end
                tests++;
                if (ceb === 1'b1 && clk_out !== 1'b0) begin
                    failures++;
                    $display("FAIL ceb_implies_low cycle %0d: got clk_out=%b with ceb=1, expected 0", x.cyc, clk_out);
                end
            end
        end
    end

    initial begin
        int hold;
        logic en_lvl;
        logic [DIV_W-1:0] div_v;

        rst = 1'b1;
        en  = 1'b1;
        div = 8'd2;

        // Reset held with en high, then a clean start at div=2.
        repeat (3) drive(1'b1, 1'b1, 8'd2);
        repeat (SETTLE_CYCLES + 60) drive(1'b0, 1'b1, 8'd2);
        // div change mid-run must not affect the period.
        repeat (20) drive(1'b0, 1'b1, 8'd7);
        // Shutdown with en toggling during STOP/DRAIN.
        drive(1'b0, 1'b0, 8'd7);
        for (int i = 0; i < 12; i++) drive(1'b0, logic'(i % 2), 8'd7);
        repeat (6) drive(1'b0, 1'b0, 8'd7);
        // Abort during SETTLE.
        repeat (5) drive(1'b0, 1'b1, 8'd0);
        repeat (8) drive(1'b0, 1'b0, 8'd0);
        // div=0 gives clk/2.
        repeat (SETTLE_CYCLES + 12) drive(1'b0, 1'b1, 8'd0);
        // Reset in the middle of a run.
        repeat (SETTLE_CYCLES + 4) drive(1'b0, 1'b1, 8'd3);
        drive(1'b1, 1'b1, 8'd3);
        repeat (3) drive(1'b0, 1'b0, 8'd3);

        // Randomized level holds, div churn and rare resets.
        hold   = 0;
        en_lvl = 1'b0;
        div_v  = 8'd1;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                en_lvl = logic'($urandom_range(0, 1));
                hold   = $urandom_range(1, 90);
            end
            hold--;
            if ($urandom_range(0, 3) == 0) div_v = DIV_W'($urandom_range(0, 5));
            drive(logic'($urandom_range(0, 599) == 0), en_lvl, div_v);
        end
        repeat (60) drive(1'b0, 1'b0, 8'd0);

        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
